// File: rtl/keypad_scanner_4x4_if.sv
// keypad_scanner_4x4_if: keypad pins and key-code outputs of the 4x4 keypad scanner.
interface keypad_scanner_4x4_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  modport master (input key_row, output key_col, key_code, key_valid, key_held);
  modport slave  (output key_row, input key_col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: column-scans a 4x4 active-low keypad, debounces and reports each press once.
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic clk,
  input logic rst,
  keypad_scanner_4x4_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        state_q;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, cand_q, low_idx;
  logic [3:0]    cnt_q, rcnt_q, code_q, low;
  logic          valid_q, held_q, smp, any_low, cand_low, match;
  always_comb begin
    low      = ~row_s2_q;
    any_low  = |low;
    low_idx  = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    smp      = div_q == DW'(SCAN_DIV - 1);
    div_d    = smp ? '0 : div_q + DW'(1);
    cand_low = low[cand_q];
    match    = cand_low && low_idx == cand_q;
  end
  // synchronizer idles high so a reset never looks like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
    end else begin
      row_s1_q <= kp.key_row;
      row_s2_q <= row_s1_q;
      div_q    <= div_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      cand_q  <= 2'd0;
      cnt_q   <= 4'd0;
      rcnt_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (smp)
        case (state_q)
          SCAN:
            if (any_low) begin
              cand_q  <= low_idx;
              cnt_q   <= 4'd0;
              state_q <= DEBOUNCE;
            end else col_q <= col_q + 2'd1;
          DEBOUNCE:
            if (!match) begin
              state_q <= SCAN;
              col_q   <= col_q + 2'd1;
            end else if (cnt_q + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              code_q  <= {cand_q, col_q};
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              rcnt_q  <= 4'd0;
              state_q <= HELD;
            end else cnt_q <= cnt_q + 4'd1;
          HELD:
            if (cand_low) rcnt_q <= 4'd0;
            else if (rcnt_q + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              held_q  <= 1'b0;
              state_q <= SCAN;
              col_q   <= col_q + 2'd1;
            end else rcnt_q <= rcnt_q + 4'd1;
          default: state_q <= SCAN;
        endcase
    end
  end
  assign kp.key_col   = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
endmodule
